// File: rtl/ysyx_25060170_ifetch.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25060170_ifetch
// Brief    : Single-outstanding AXI-lite style instruction fetcher with redirect/kill.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25060170_ifetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        core_ready,
   output logic        inst_valid,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   output logic        fetch_err,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_pc;
   logic [31:0] w_pc_next;
   logic        r_kill;
   logic        w_kill_next;
   logic        w_capture;
   logic [31:0] r_araddr;
   logic [31:0] r_inst;
   logic [31:0] r_pc_o;
   logic        r_err;

   // Redirect always wins; in ADDR/DATA it only retargets pc and marks the
   // in-flight beat for discard, so the bus handshake is never disturbed.
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_kill_next  = r_kill;
      w_capture    = 1'b0;
      case (r_state)
         IDLE: begin
            w_state_next = ADDR;
            if (redirect) w_pc_next = redirect_pc;
         end
         ADDR: begin
            if (redirect) begin
               w_pc_next   = redirect_pc;
               w_kill_next = 1'b1;
            end
            if (arready) w_state_next = DATA;
         end
         DATA: begin
            if (redirect) begin
               w_pc_next   = redirect_pc;
               w_kill_next = 1'b1;
            end
            if (rvalid) begin
               w_kill_next = 1'b0;
               if (r_kill || redirect) begin
                  w_state_next = ADDR;
               end else begin
                  w_state_next = HOLD;
                  w_capture    = 1'b1;
               end
            end
         end
         HOLD: begin
            if (redirect) begin
               w_pc_next    = redirect_pc;
               w_state_next = ADDR;
            end else if (core_ready) begin
               w_pc_next    = r_pc + 32'd4;
               w_state_next = ADDR;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_pc     <= RESET_PC;
         r_kill   <= 1'b0;
         r_araddr <= RESET_PC;
         r_inst   <= 32'd0;
         r_pc_o   <= 32'd0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_kill  <= w_kill_next;
         // araddr is latched only on entry to ADDR so it stays frozen until arready
         if (w_state_next == ADDR && r_state != ADDR) begin
            r_araddr <= w_pc_next;
         end
         if (w_capture) begin
            r_inst <= rdata;
            r_pc_o <= r_pc;
            r_err  <= |rresp;
         end
      end
   end

   assign arvalid    = (r_state == ADDR);
   assign rready     = (r_state == DATA);
   assign inst_valid = (r_state == HOLD);
   assign araddr     = r_araddr;
   assign inst_o     = r_inst;
   assign pc_o       = r_pc_o;
   assign fetch_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25060170_ifetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25060170_ifetch
// Brief    : Directed latency checks plus randomized run against a fetch-stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25060170_ifetch;

   localparam logic [31:0] c_reset_pc = 32'h8000_0000;

   logic        clock;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        core_ready;
   logic        inst_valid;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic        fetch_err;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   ysyx_25060170_ifetch #(.RESET_PC(c_reset_pc)) u_dut (
      .clock       (clock),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .core_ready  (core_ready),
      .inst_valid  (inst_valid),
      .inst_o      (inst_o),
      .pc_o        (pc_o),
      .fetch_err   (fetch_err),
      .araddr      (araddr),
      .arvalid     (arvalid),
      .arready     (arready),
      .rdata       (rdata),
      .rresp       (rresp),
      .rvalid      (rvalid),
      .rready      (rready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_tests;
   int n_fail;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // memory responder knobs
   logic        mem_pend;
   int          mem_cnt;
   int          ar_cnt;
   int          ar_wait;
   int          r_delay;
   logic [31:0] next_rdata;
   logic [1:0]  next_rresp;

   task automatic tick();
      logic arf;
      logic rf;
      arf = arvalid && arready;
      rf  = rvalid && rready;
      @(posedge clock);
      #1;
      if (rf) begin
         rvalid   = 1'b0;
         mem_pend = 1'b0;
      end
      if (arf) begin
         mem_pend = 1'b1;
         mem_cnt  = r_delay;
         ar_cnt   = 0;
      end
      if (mem_pend && !rvalid) begin
         if (mem_cnt == 0) begin
            rvalid = 1'b1;
            rdata  = next_rdata;
            rresp  = next_rresp;
         end else begin
            mem_cnt--;
         end
      end
      arready = 1'b0;
      if (arvalid && !mem_pend) begin
         arready = (ar_cnt >= ar_wait);
         ar_cnt++;
      end
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      redirect   = 1'b0;
      core_ready = 1'b0;
      arready    = 1'b0;
      rvalid     = 1'b0;
      mem_pend   = 1'b0;
      ar_cnt     = 0;
      tick();
      tick();
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_inst_o", inst_o, 0);
      chk("rst_pc_o", pc_o, 0);
      chk("rst_fetch_err", fetch_err, 0);
      chk("rst_araddr", araddr, c_reset_pc);
      reset = 1'b0;
   endtask

   // Transaction-level model: the stream of delivered instructions must follow
   // the architectural pc sequence; each redirect starts a new generation and
   // any beat requested in an older generation must vanish.
   logic [31:0] m_pc;
   logic        m_valid;
   logic [31:0] m_inst;
   logic [31:0] m_pco;
   logic        m_err;
   logic        m_ar_active;
   logic [31:0] m_ar_addr;
   int          m_ar_gen;
   logic        m_outst;
   logic [31:0] m_out_addr;
   int          m_out_gen;
   int          m_gen;
   int          m_idle;

   always @(negedge clock) begin
      if (reset) begin
         m_pc        = c_reset_pc;
         m_valid     = 1'b0;
         m_ar_active = 1'b0;
         m_outst     = 1'b0;
         m_gen       = 0;
         m_idle      = 0;
      end else begin
         logic rf;
         chk("m_inst_valid", inst_valid, m_valid);
         if (m_valid) begin
            chk("m_inst_o", inst_o, m_inst);
            chk("m_pc_o", pc_o, m_pco);
            chk("m_fetch_err", fetch_err, m_err);
         end
         if (arvalid) begin
            chk("m_ar_exclusive", {31'd0, m_valid || m_outst}, 0);
            if (m_ar_active) begin
               chk("m_araddr_stable", araddr, m_ar_addr);
            end else begin
               chk("m_araddr_start", araddr, m_pc);
               m_ar_active = 1'b1;
               m_ar_addr   = araddr;
               m_ar_gen    = m_gen;
               m_idle      = 0;
            end
         end
         if (rvalid) chk("m_rready", rready, 1);
         if (arvalid && arready) begin
            m_ar_active = 1'b0;
            m_outst     = 1'b1;
            m_out_addr  = m_ar_addr;
            m_out_gen   = m_ar_gen;
         end
         rf = rvalid && rready;
         if (rf) m_outst = 1'b0;
         if (redirect) begin
            m_gen++;
            m_pc    = redirect_pc;
            m_valid = 1'b0;
            m_idle  = 0;
         end else if (m_valid && core_ready) begin
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b0;
            m_idle  = 0;
         end
         if (rf && m_out_gen == m_gen) begin
            m_valid = 1'b1;
            m_inst  = rdata;
            m_pco   = m_out_addr;
            m_err   = (rresp != 2'b00);
         end
         m_idle++;
         if (m_idle >= 64) begin
            chk("watchdog_stall", m_idle, 0);
            m_idle = 0;
         end
      end
   end

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      redirect_pc = 32'd0;
      rdata       = 32'd0;
      rresp       = 2'b00;
      ar_wait     = 0;
      r_delay     = 0;
      mem_cnt     = 0;
      next_rdata  = 32'h0000_0413;
      next_rresp  = 2'b00;
      do_reset();

      // zero-wait fetch latency
      core_ready = 1'b1;
      tick();
      chk("lat_arvalid", arvalid, 1);
      chk("lat_araddr", araddr, 32'h8000_0000);
      tick();
      chk("lat_data_not_valid", inst_valid, 0);
      tick();
      chk("lat_valid", inst_valid, 1);
      chk("lat_inst", inst_o, 32'h0000_0413);
      chk("lat_pc", pc_o, 32'h8000_0000);
      next_rdata = 32'h0010_0093;
      tick();
      chk("lat_next_araddr", araddr, 32'h8000_0004);
      core_ready = 1'b0;

      // back-pressure in HOLD
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", inst_valid, 1);
         chk("hold_inst", inst_o, 32'h0010_0093);
         chk("hold_pc", pc_o, 32'h8000_0004);
         chk("hold_no_ar", arvalid, 0);
         if (i < 4) tick();
      end
      core_ready = 1'b1;
      ar_wait    = 3;
      next_rdata = 32'hBAD0_0001;
      tick();
      core_ready = 1'b0;
      chk("hold_next_araddr", araddr, 32'h8000_0008);

      // redirect while AR stalls
      tick();
      chk("kill_araddr_c2", araddr, 32'h8000_0008);
      redirect    = 1'b1;
      redirect_pc = 32'h8000_0100;
      tick();
      redirect = 1'b0;
      chk("kill_araddr_c3", araddr, 32'h8000_0008);
      chk("kill_arvalid_c3", arvalid, 1);
      tick();
      chk("kill_araddr_c4", araddr, 32'h8000_0008);
      ar_wait = 0;
      tick();
      chk("kill_data_no_valid", inst_valid, 0);
      tick();
      chk("kill_discard", inst_valid, 0);
      chk("kill_new_arvalid", arvalid, 1);
      chk("kill_new_araddr", araddr, 32'h8000_0100);
      next_rdata = 32'h0000_0513;
      tick();
      tick();
      chk("kill_after_valid", inst_valid, 1);
      chk("kill_after_pc", pc_o, 32'h8000_0100);
      chk("kill_after_inst", inst_o, 32'h0000_0513);

      // redirect beats transfer in HOLD
      core_ready  = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h8000_0200;
      tick();
      redirect   = 1'b0;
      core_ready = 1'b0;
      chk("redir_hold_valid", inst_valid, 0);
      chk("redir_hold_araddr", araddr, 32'h8000_0200);

      // error response then clean response
      next_rdata = 32'hDEAD_BEEF;
      next_rresp = 2'b10;
      tick();
      tick();
      chk("err_valid", inst_valid, 1);
      chk("err_flag", fetch_err, 1);
      chk("err_inst", inst_o, 32'hDEAD_BEEF);
      next_rresp = 2'b00;
      next_rdata = 32'h0000_0613;
      core_ready = 1'b1;
      tick();
      core_ready = 1'b0;
      chk("err_next_araddr", araddr, 32'h8000_0204);
      tick();
      tick();
      chk("ok_valid", inst_valid, 1);
      chk("ok_flag", fetch_err, 0);
      chk("ok_pc", pc_o, 32'h8000_0204);

      // pc wrap
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      chk("wrap_araddr_top", araddr, 32'hFFFF_FFFC);
      tick();
      tick();
      chk("wrap_pc_o", pc_o, 32'hFFFF_FFFC);
      core_ready = 1'b1;
      tick();
      core_ready = 1'b0;
      chk("wrap_araddr_zero", araddr, 32'h0000_0000);

      // randomized run, model checks every cycle
      for (int i = 0; i < 4000; i++) begin
         core_ready  = ($urandom_range(0, 3) != 0);
         redirect    = ($urandom_range(0, 11) == 0);
         redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
         if (ar_cnt == 0) ar_wait = $urandom_range(0, 3);
         r_delay    = $urandom_range(0, 3);
         next_rdata = $urandom;
         next_rresp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         if (i == 2000) do_reset();
         tick();
      end
      redirect   = 1'b0;
      core_ready = 1'b1;
      repeat (10) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
